// File: rtl/control_if.sv
// control_if: decode/status bundle between the control unit and the datapath.
interface control_if #(parameter int CNT_W = 16);
   logic [5:0]       Opcode;
   logic             zero;
   logic             s_inc;
   logic             s_inm;
   logic             we;
   logic             wez;
   logic [2:0]       ALUOp;
   logic             halted;
   logic             illegal;
   logic [CNT_W-1:0] instr_count;
   modport master (input Opcode, zero,
                   output s_inc, s_inm, we, wez, ALUOp, halted, illegal, instr_count);
   modport slave  (output Opcode, zero,
                   input s_inc, s_inm, we, wez, ALUOp, halted, illegal, instr_count);
endinterface

// File: rtl/control_unit.sv
// control_unit: combinational opcode decode with RUN/HALTED FSM,
// sticky illegal-opcode flag and saturating retired-instruction counter.
module control_unit #(
   parameter int         CNT_W    = 16,
   parameter logic [2:0] LI_ALUOP = 3'b000
) (
   input logic       clk,
   input logic       reset,
   control_if.master bus
);
   typedef enum logic {RUN, HALTED} state_e;
   state_e           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             s_inc, s_inm, we, wez, is_halt, is_ill;
   logic [2:0]       alu_op;
   logic [5:0]       op;
   assign op = bus.Opcode;
   always_comb begin
      s_inc   = 1'b1;
      s_inm   = 1'b0;
      we      = 1'b0;
      wez     = 1'b0;
      alu_op  = 3'b000;
      is_halt = 1'b0;
      is_ill  = 1'b0;
      if (state_q == HALTED) begin
         s_inc = 1'b0;
      end else if (!op[5]) begin
         alu_op = op[4:2];
         we     = 1'b1;
         wez    = 1'b1;
      end else if (op[5:2] == 4'b1000) begin
         s_inm  = 1'b1;
         alu_op = LI_ALUOP;
         we     = 1'b1;
      end else if (op == 6'b110000) begin
         s_inc = 1'b0;
      end else if (op == 6'b110001) begin
         s_inc = ~bus.zero;
      end else if (op == 6'b110010) begin
         s_inc = bus.zero;
      end else if (op == 6'b111111) begin
         s_inc   = 1'b0;
         is_halt = 1'b1;
      end else begin
         is_ill = 1'b1;
      end
      state_d   = is_halt ? HALTED : state_q;
      illegal_d = illegal_q | is_ill;
      // The HALT instruction itself retires, so counting is gated by the current state only.
      cnt_d     = (state_q == RUN && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end
   assign bus.s_inc       = s_inc;
   assign bus.s_inm       = s_inm;
   assign bus.we          = we;
   assign bus.wez         = wez;
   assign bus.ALUOp       = alu_op;
   assign bus.halted      = (state_q == HALTED);
   assign bus.illegal     = illegal_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed stimulus on two DUTs (CNT_W=16 and CNT_W=4) sharing inputs,
// checked every cycle against an instruction-level model plus literal expectations.
module tb_control_unit;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic       z = 1'b0;
   int         checks = 0;
   int         errors = 0;

   control_if #(.CNT_W(16)) b16();
   control_if #(.CNT_W(4))  b4();
   assign b16.Opcode = op;
   assign b16.zero   = z;
   assign b4.Opcode  = op;
   assign b4.zero    = z;

   control_unit #(.CNT_W(16)) dut16 (.clk(clk), .reset(rst), .bus(b16.master));
   control_unit #(.CNT_W(4))  dut4  (.clk(clk), .reset(rst), .bus(b4.master));

   always #5 clk = ~clk;

   // Model: retired count (unbounded, saturated when compared), halt and illegal flags.
   int   m_retired;
   logic m_halt, m_ill;

   function automatic logic is_legal(input logic [5:0] o);
      return !o[5] || o[5:2] == 4'b1000 ||
             o == 6'b110000 || o == 6'b110001 || o == 6'b110010 || o == 6'b111111;
   endfunction

   // {s_inc, s_inm, we, wez, ALUOp}
   function automatic logic [6:0] exp_dec(input logic [5:0] o, input logic zf, input logic h);
      if (h) return 7'b0;
      casez (o)
         6'b0?????: return {4'b1011, o[4:2]};
         6'b1000??: return 7'b1110_000;
         6'b110000: return 7'b0;
         6'b110001: return {~zf, 6'b0};
         6'b110010: return {zf, 6'b0};
         6'b111111: return 7'b0;
         default:   return 7'b1000_000;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_retired <= 0;
         m_halt    <= 1'b0;
         m_ill     <= 1'b0;
      end else if (!m_halt) begin
         m_retired <= m_retired + 1;
         if (!is_legal(op)) m_ill <= 1'b1;
         if (op == 6'b111111) m_halt <= 1'b1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("dec16", int'({b16.s_inc, b16.s_inm, b16.we, b16.wez, b16.ALUOp}), int'(exp_dec(op, z, m_halt)));
         chk("dec4", int'({b4.s_inc, b4.s_inm, b4.we, b4.wez, b4.ALUOp}), int'(exp_dec(op, z, m_halt)));
         chk("cnt16", int'(b16.instr_count), m_retired > 65535 ? 65535 : m_retired);
         chk("cnt4", int'(b4.instr_count), m_retired > 15 ? 15 : m_retired);
         chk("halted", int'({b16.halted, b4.halted}), m_halt ? 3 : 0);
         chk("illegal", int'({b16.illegal, b4.illegal}), m_ill ? 3 : 0);
      end
   end

   task automatic apply(input logic [5:0] o, input logic zf);
      op = o;
      z  = zf;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   initial begin
      #12 rst = 1'b0;
      chk("rst_cnt", int'(b16.instr_count), 0);
      chk("rst_halted", int'(b16.halted), 0);
      chk("rst_illegal", int'(b16.illegal), 0);
      // R-type ALUOp 3
      apply(6'b0_011_00, 1'b0);
      chk("rtype_dec", int'({b16.s_inc, b16.s_inm, b16.we, b16.wez, b16.ALUOp}), 7'b1011_011);
      tick();
      chk("rtype_cnt", int'(b16.instr_count), 1);
      // LI
      apply(6'b100000, 1'b0);
      chk("li_dec", int'({b16.s_inc, b16.s_inm, b16.we, b16.wez, b16.ALUOp}), 7'b1110_000);
      tick();
      // JZ / JNZ
      apply(6'b110001, 1'b1);
      chk("jz_z1", int'({b16.s_inc, b16.we, b16.wez}), 3'b000);
      tick();
      apply(6'b110001, 1'b0);
      chk("jz_z0", int'({b16.s_inc, b16.we, b16.wez}), 3'b100);
      tick();
      apply(6'b110010, 1'b1);
      chk("jnz_z1", int'({b16.s_inc, b16.we, b16.wez}), 3'b100);
      tick();
      apply(6'b110010, 1'b0);
      chk("jnz_z0", int'({b16.s_inc, b16.we, b16.wez}), 3'b000);
      tick();
      apply(6'b110000, 1'b0);
      tick();
      chk("cnt_7", int'(b16.instr_count), 7);
      // HALT after 5 instructions
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         apply(6'(i << 2), 1'b0);
         tick();
      end
      apply(6'b111111, 1'b0);
      chk("halt_cycle", int'({b16.s_inc, b16.we, b16.wez, b16.halted}), 4'b0000);
      tick();
      chk("halt_cnt", int'(b16.instr_count), 6);
      chk("halt_flag", int'(b16.halted), 1);
      for (int i = 0; i < 10; i++) begin
         apply(6'b0_101_00, 1'b1);
         tick();
      end
      chk("halted_dec", int'({b16.s_inc, b16.s_inm, b16.we, b16.wez, b16.ALUOp}), 0);
      chk("halted_cnt", int'(b16.instr_count), 6);
      // Illegal opcode
      pulse_reset();
      apply(6'b101100, 1'b0);
      chk("ill_nop", int'({b16.s_inc, b16.s_inm, b16.we, b16.wez, b16.ALUOp}), 7'b1000_000);
      tick();
      chk("ill_set", int'(b16.illegal), 1);
      apply(6'b0_001_00, 1'b0);
      tick();
      apply(6'b100001, 1'b0);
      tick();
      chk("ill_sticky", int'(b16.illegal), 1);
      chk("ill_cnt", int'(b16.instr_count), 3);
      pulse_reset();
      chk("ill_clr", int'(b16.illegal), 0);
      // Saturation with CNT_W=4
      for (int i = 0; i < 20; i++) begin
         apply(6'b0_110_00, 1'b0);
         tick();
      end
      chk("sat4", int'(b4.instr_count), 15);
      chk("cnt16_20", int'(b16.instr_count), 20);
      apply(6'b111111, 1'b0);
      tick();
      apply(6'b0_010_00, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_cnt4", int'(b4.instr_count), 0);
      chk("async_cnt16", int'(b16.instr_count), 0);
      chk("async_halted", int'({b16.halted, b4.halted}), 0);
      chk("async_dec", int'({b16.s_inc, b16.we, b16.wez}), 3'b111);
      rst = 1'b0;
      tick();
      tick();
      chk("resume_cnt", int'(b16.instr_count), 2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
